// File: rtl/float_copro_issue_if.sv
// Bus bundle between the LM32 user-instruction port, the issue sequencer and float_copro.
// The master modport is the issue sequencer; the slave modport is the CPU/coprocessor side.
interface float_copro_issue_if;
  logic        cpu_start;
  logic [10:0] cpu_opcode;
  logic [31:0] cpu_op0;
  logic [31:0] cpu_op1;
  logic        cpu_done;
  logic [31:0] cpu_result;
  logic        cpu_error;
  logic        cpu_busy;
  logic        copro_valid;
  logic        copro_accept;
  logic [10:0] copro_opcode;
  logic [31:0] copro_op0;
  logic [31:0] copro_op1;
  logic        copro_complete;
  logic [31:0] copro_result;

  modport master (
    input  cpu_start, cpu_opcode, cpu_op0, cpu_op1, copro_complete, copro_result,
    output cpu_done, cpu_result, cpu_error, cpu_busy,
    output copro_valid, copro_accept, copro_opcode, copro_op0, copro_op1
  );

  modport slave (
    output cpu_start, cpu_opcode, cpu_op0, cpu_op1, copro_complete, copro_result,
    input  cpu_done, cpu_result, cpu_error, cpu_busy,
    input  copro_valid, copro_accept, copro_opcode, copro_op0, copro_op1
  );
endinterface

// File: rtl/float_copro_issue.sv
// Issue/handshake sequencer between the LM32 user-instruction port and float_copro.
// Holds a request on the copro_* bus, runs valid/complete/accept and returns a one-cycle done pulse.
module float_copro_issue #(
  parameter logic [10:0] MAX_OPCODE = 11'd3,
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] NAN_RESULT = 32'h7FC0_0000
) (
  input  logic                clk,
  input  logic                reset_n,
  float_copro_issue_if.master bus,
  output logic [15:0]         op_count
);

  localparam int unsigned      TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             copro_valid_q, copro_valid_d;
  logic             copro_accept_q, copro_accept_d;
  logic             cpu_done_q, cpu_done_d;
  logic             cpu_busy_q, cpu_busy_d;
  logic             cpu_error_q, cpu_error_d;
  logic [31:0]      cpu_result_q, cpu_result_d;
  logic [10:0]      copro_opcode_q, copro_opcode_d;
  logic [31:0]      copro_op0_q, copro_op0_d;
  logic [31:0]      copro_op1_q, copro_op1_d;
  logic [15:0]      op_count_q, op_count_d;
  logic             opcode_legal_s;

  assign opcode_legal_s = (bus.cpu_opcode <= MAX_OPCODE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; complete outside WAIT and start outside IDLE are ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_start) begin
          state_d = opcode_legal_s ? S_ISSUE : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.copro_complete) begin
          state_d = S_ACK;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_ACK:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; handshake outputs decode the state being entered so they are flops.
  always_comb begin
    tmo_d          = tmo_q;
    cpu_result_d   = cpu_result_q;
    cpu_error_d    = cpu_error_q;
    copro_opcode_d = copro_opcode_q;
    copro_op0_d    = copro_op0_q;
    copro_op1_d    = copro_op1_q;
    op_count_d     = op_count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_start && opcode_legal_s) begin
          copro_opcode_d = bus.cpu_opcode;
          copro_op0_d    = bus.cpu_op0;
          copro_op1_d    = bus.cpu_op1;
        end else if (bus.cpu_start) begin
          cpu_result_d = NAN_RESULT;
          cpu_error_d  = 1'b1;
        end else begin
          tmo_d = tmo_q;
        end
      end
      S_ISSUE: tmo_d = {TMO_W{1'b0}};
      S_WAIT: begin
        if (bus.copro_complete) begin
          cpu_result_d = bus.copro_result;
          cpu_error_d  = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          cpu_result_d = NAN_RESULT;
          cpu_error_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1'b1);
        end
      end
      S_ACK: tmo_d = tmo_q;
      S_DONE: begin
        if (!cpu_error_q && (op_count_q != 16'hFFFF)) begin
          op_count_d = op_count_q + 16'd1;
        end else begin
          op_count_d = op_count_q;
        end
      end
      default: tmo_d = tmo_q;
    endcase
    copro_valid_d  = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_ACK);
    copro_accept_d = (state_d == S_ACK);
    cpu_done_d     = (state_d == S_DONE);
    cpu_busy_d     = (state_d != S_IDLE);
  end

  // Registered outputs and datapath; reset drops copro_valid without waiting for a clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q          <= {TMO_W{1'b0}};
      copro_valid_q  <= 1'b0;
      copro_accept_q <= 1'b0;
      cpu_done_q     <= 1'b0;
      cpu_busy_q     <= 1'b0;
      cpu_error_q    <= 1'b0;
      cpu_result_q   <= 32'h0000_0000;
      copro_opcode_q <= 11'd0;
      copro_op0_q    <= 32'h0000_0000;
      copro_op1_q    <= 32'h0000_0000;
      op_count_q     <= 16'h0000;
    end else begin
      tmo_q          <= tmo_d;
      copro_valid_q  <= copro_valid_d;
      copro_accept_q <= copro_accept_d;
      cpu_done_q     <= cpu_done_d;
      cpu_busy_q     <= cpu_busy_d;
      cpu_error_q    <= cpu_error_d;
      cpu_result_q   <= cpu_result_d;
      copro_opcode_q <= copro_opcode_d;
      copro_op0_q    <= copro_op0_d;
      copro_op1_q    <= copro_op1_d;
      op_count_q     <= op_count_d;
    end
  end

  assign bus.copro_valid  = copro_valid_q;
  assign bus.copro_accept = copro_accept_q;
  assign bus.copro_opcode = copro_opcode_q;
  assign bus.copro_op0    = copro_op0_q;
  assign bus.copro_op1    = copro_op1_q;
  assign bus.cpu_done     = cpu_done_q;
  assign bus.cpu_busy     = cpu_busy_q;
  assign bus.cpu_error    = cpu_error_q;
  assign bus.cpu_result   = cpu_result_q;
  assign op_count         = op_count_q;

endmodule

// File: tb/tb_float_copro_issue.sv
// Scoreboard bench for float_copro_issue: a driver pushes model expectations, a monitor pops them on cpu_done.
// A responder process plays the coprocessor, completing k cycles after copro_valid rises.
module tb_float_copro_issue;
  localparam int          TIMEOUT = 64;
  localparam logic [10:0] MAX_OPC = 11'd3;
  localparam logic [31:0] NAN     = 32'h7FC0_0000;

  typedef struct {
    logic [31:0] result;
    logic        error;
    int          cyc;
    int          vlen;
    int          acc;
    logic [10:0] opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] op_count;
  float_copro_issue_if bus();

  float_copro_issue #(
    .MAX_OPCODE (MAX_OPC),
    .TIMEOUT    (TIMEOUT),
    .NAN_RESULT (NAN)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .op_count (op_count)
  );

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          resp_k = 0;
  logic [31:0] resp_val = 32'h0;
  logic [15:0] model_cnt = 16'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got 1 expected 0 (cycle %0d)", name, cyc);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},  32'(bus.copro_valid), 32'd0);
    chk({tag, "_accept"}, 32'(bus.copro_accept), 32'd0);
    chk({tag, "_done"},   32'(bus.cpu_done), 32'd0);
    chk({tag, "_busy"},   32'(bus.cpu_busy), 32'd0);
    chk({tag, "_error"},  32'(bus.cpu_error), 32'd0);
    chk({tag, "_result"}, bus.cpu_result, 32'd0);
    chk({tag, "_opcode"}, 32'(bus.copro_opcode), 32'd0);
    chk({tag, "_op0"},    bus.copro_op0, 32'd0);
    chk({tag, "_op1"},    bus.copro_op1, 32'd0);
    chk({tag, "_count"},  32'(op_count), 32'd0);
  endtask

  // One request from a negedge; returns on the negedge of the first IDLE cycle afterwards.
  task automatic run_txn(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input int k, input logic [31:0] val, input bit junk);
    exp_t e;
    int   lat;
    bit   legal;
    bit   ok;
    legal = (opc <= MAX_OPC);
    ok    = legal && (k >= 1) && (k <= TIMEOUT);
    lat   = !legal ? 1 : (ok ? k + 3 : TIMEOUT + 2);
    if (ok && (model_cnt != 16'hFFFF)) model_cnt = model_cnt + 16'd1;
    e.result = ok ? val : NAN;
    e.error  = ~ok;
    e.cyc    = cyc + lat;
    e.vlen   = !legal ? 0 : (ok ? k + 2 : TIMEOUT + 1);
    e.acc    = ok ? 1 : 0;
    e.opc    = opc;
    e.a      = a;
    e.b      = b;
    e.cnt    = model_cnt;
    resp_k   = k;
    resp_val = val;
    sb_q.push_back(e);
    bus.cpu_start  = 1'b1;
    bus.cpu_opcode = opc;
    bus.cpu_op0    = a;
    bus.cpu_op1    = b;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      bus.cpu_start  = junk && ((c == 2) || (c == lat) || ($urandom_range(0, 3) == 0));
      bus.cpu_opcode = 11'($urandom_range(0, 7));
      bus.cpu_op0    = $urandom;
      bus.cpu_op1    = $urandom;
      chk("busy_active", 32'(bus.cpu_busy), 32'd1);
    end
    @(negedge clk);
    bus.cpu_start = 1'b0;
    chk("busy_idle", 32'(bus.cpu_busy), 32'd0);
  endtask

  // Coprocessor model: completes k cycles after valid rises, random noise on complete while valid is low.
  initial begin : responder
    int cnt;
    bit active;
    bit vprev;
    cnt = 0;
    active = 1'b0;
    vprev = 1'b0;
    bus.copro_complete = 1'b0;
    bus.copro_result   = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.copro_valid && !vprev) begin
        active = 1'b1;
        cnt = 0;
      end else if (active) begin
        cnt++;
      end
      if (!bus.copro_valid) active = 1'b0;
      vprev = bus.copro_valid;
      if (active) begin
        bus.copro_complete = (cnt == resp_k);
        bus.copro_result   = (cnt == resp_k) ? resp_val : $urandom;
      end else begin
        bus.copro_complete = ($urandom_range(0, 3) == 0);
        bus.copro_result   = $urandom;
      end
    end
  end

  initial begin : monitor
    exp_t        cur;
    int          vrun;
    int          acc_n;
    bit          cnt_pend;
    logic [15:0] cnt_exp;
    vrun = 0;
    acc_n = 0;
    cnt_pend = 1'b0;
    cnt_exp = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        vrun = 0;
        acc_n = 0;
        cnt_pend = 1'b0;
      end else begin
        if (cnt_pend) begin
          chk("op_count", 32'(op_count), 32'(cnt_exp));
          cnt_pend = 1'b0;
        end
        if (bus.copro_valid) begin
          vrun++;
          if (sb_q.size() == 0) begin
            fail("spurious_valid");
          end else begin
            chk("copro_opcode", 32'(bus.copro_opcode), 32'(sb_q[0].opc));
            chk("copro_op0", bus.copro_op0, sb_q[0].a);
            chk("copro_op1", bus.copro_op1, sb_q[0].b);
          end
        end
        if (bus.copro_accept) acc_n++;
        if (bus.cpu_done) begin
          if (sb_q.size() == 0) begin
            fail("unexpected_done");
          end else begin
            cur = sb_q.pop_front();
            chk("cpu_result", bus.cpu_result, cur.result);
            chk("cpu_error", 32'(bus.cpu_error), 32'(cur.error));
            chk("done_cycle", cyc, cur.cyc);
            chk("valid_cycles", vrun, cur.vlen);
            chk("accept_pulses", acc_n, cur.acc);
            cnt_exp = cur.cnt;
            cnt_pend = 1'b1;
          end
          vrun = 0;
          acc_n = 0;
        end
      end
    end
  end

  initial begin : driver
    exp_t        e;
    logic [10:0] opc;
    int          sel;
    int          k;
    reset_n        = 1'b0;
    bus.cpu_start  = 1'b0;
    bus.cpu_opcode = 11'd0;
    bus.cpu_op0    = 32'h0;
    bus.cpu_op1    = 32'h0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Directed: add, illegal opcode, timeout, back-to-back with ignored starts.
    run_txn(11'd0, 32'h3F80_0000, 32'h4000_0000, 2, 32'h4040_0000, 1'b0);
    run_txn(11'd7, 32'h1234_5678, 32'h9ABC_DEF0, 2, 32'h1111_1111, 1'b0);
    run_txn(11'd3, 32'h4120_0000, 32'h0000_0000, TIMEOUT + 1000, 32'h2222_2222, 1'b0);
    run_txn(11'd2, 32'hC000_0000, 32'h4080_0000, 3, 32'hC100_0000, 1'b1);
    run_txn(11'd1, 32'h4100_0000, 32'h3F80_0000, 4, 32'h40E0_0000, 1'b0);
    // Complete on the last WAIT cycle succeeds; one later, or during ISSUE, times out.
    run_txn(11'd0, $urandom, $urandom, TIMEOUT, $urandom, 1'b0);
    run_txn(11'd1, $urandom, $urandom, TIMEOUT + 1, $urandom, 1'b0);
    run_txn(11'd2, $urandom, $urandom, 0, $urandom, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    e.opc = 11'd3; e.a = $urandom; e.b = $urandom;
    e.result = 32'h0; e.error = 1'b0; e.cyc = 0; e.vlen = 0; e.acc = 0; e.cnt = 16'h0;
    resp_k = 40;
    resp_val = $urandom;
    sb_q.push_back(e);
    bus.cpu_start = 1'b1; bus.cpu_opcode = e.opc; bus.cpu_op0 = e.a; bus.cpu_op1 = e.b;
    @(negedge clk);
    bus.cpu_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", 32'(bus.copro_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1 check_zero("mid_reset");
    sb_q.delete();
    model_cnt = 16'h0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    run_txn(11'd2, $urandom, $urandom, 2, $urandom, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 120; i++) begin
      opc = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(4, 2047)) : 11'($urandom_range(0, 3));
      sel = $urandom_range(0, 11);
      k = (sel == 0) ? 0 : (sel == 1) ? TIMEOUT : (sel == 2) ? TIMEOUT + 1 : $urandom_range(1, 6);
      run_txn(opc, $urandom, $urandom, k, $urandom, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Saturation: preload the counter just below the top.
    @(negedge clk);
    #2 force dut.op_count_q = 16'hFFFD;
    @(posedge clk);
    #1 release dut.op_count_q;
    model_cnt = 16'hFFFD;
    @(negedge clk);
    chk("preload", 32'(op_count), 32'h0000_FFFD);
    for (int i = 0; i < 4; i++) begin
      run_txn(11'($urandom_range(0, 3)), $urandom, $urandom, 1, $urandom, 1'b0);
    end
    run_txn(11'd9, $urandom, $urandom, 1, $urandom, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
